// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - shared types, widths and address helper for the AHB responder
package ahb_pkg;

    localparam int AHB_DATA_W = 32;
    localparam int AHB_ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DATA
    } ahb_slv_state_e;

    // Byte address to word index, keeping only the low 'bits' index bits so high addresses alias
    function automatic logic [AHB_ADDR_W-1:0] word_index(input logic [AHB_ADDR_W-1:0] haddr,
                                                         input int bits);
        logic [AHB_ADDR_W-1:0] mask;
        mask = (AHB_ADDR_W'(1) << bits) - AHB_ADDR_W'(1);
        return (haddr >> 2) & mask;
    endfunction

endpackage

// File: rtl/ahb_sram.sv
// rtl/ahb_sram.sv - single-port synchronous word RAM with registered read
module ahb_sram
    import ahb_pkg::*;
#(
    parameter int ADDR_BITS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic                  re,
    input  logic [ADDR_BITS-1:0]  addr,
    input  logic [AHB_DATA_W-1:0] wdata,
    output logic [AHB_DATA_W-1:0] rdata
);

    logic [AHB_DATA_W-1:0] mem [2**ADDR_BITS];

    // Array write port; contents survive reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Read register only updates on a read request so the last read value is held
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/ahb_slave.sv
// rtl/ahb_slave.sv - AHB responder with SRAM backing and configurable wait states
module ahb_slave
    import ahb_pkg::*;
#(
    parameter int ADDR_BITS   = 8,
    parameter int WAIT_STATES = 0
) (
    input  logic                  hclk,
    input  logic                  hreset,
    input  logic                  hsel,
    input  logic [AHB_ADDR_W-1:0] haddr,
    input  logic                  hwrite,
    input  logic                  hready,
    input  logic [AHB_DATA_W-1:0] hwdata,
    output logic                  hreadyout,
    output logic [AHB_DATA_W-1:0] hrdata
);

    localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES);

    ahb_slv_state_e        state;
    ahb_slv_state_e        next_state;
    logic [3:0]            wait_cnt;
    logic [3:0]            wait_cnt_d;
    logic [ADDR_BITS-1:0]  idx_q;
    logic                  write_q;
    logic                  accept;

    logic [AHB_ADDR_W-1:0] idx_full;
    logic [ADDR_BITS-1:0]  haddr_idx;
    logic                  unused_idx_hi;

    logic                  sram_we;
    logic                  sram_re;
    logic [ADDR_BITS-1:0]  sram_addr;

    assign idx_full      = word_index(haddr, ADDR_BITS);
    assign haddr_idx     = idx_full[ADDR_BITS-1:0];
    assign unused_idx_hi = ^idx_full[AHB_ADDR_W-1:ADDR_BITS];

    // Only an idle slave accepts; pulses during WAIT/DATA are protocol violations and dropped
    assign accept = (state == IDLE) && hsel && hready;

    // Next-state and wait-counter logic
    always_comb begin
        next_state = state;
        wait_cnt_d = wait_cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = (WAIT_STATES > 0) ? WAIT : DATA;
                    wait_cnt_d = WS_LOAD;
                end
            end
            WAIT: begin
                wait_cnt_d = wait_cnt - 4'd1;
                if (wait_cnt == 4'd1) begin
                    next_state = DATA;
                end
            end
            DATA: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // State, counter, latched transfer attributes and registered hreadyout
    always_ff @(posedge hclk) begin
        if (hreset) begin
            state     <= IDLE;
            wait_cnt  <= 4'd0;
            idx_q     <= '0;
            write_q   <= 1'b0;
            hreadyout <= 1'b1;
        end else begin
            state     <= next_state;
            wait_cnt  <= wait_cnt_d;
            hreadyout <= (next_state != WAIT);
            if (accept) begin
                idx_q   <= haddr_idx;
                write_q <= hwrite;
            end
        end
    end

    // Reads fetch at the accept edge; writes commit at the edge closing DATA; reset drops a pending write
    assign sram_addr = (state == IDLE) ? haddr_idx : idx_q;
    assign sram_we   = (state == DATA) && write_q && !hreset;
    assign sram_re   = accept && !hwrite && !hreset;

    ahb_sram #(
        .ADDR_BITS (ADDR_BITS)
    ) u_sram (
        .clk   (hclk),
        .rst   (hreset),
        .we    (sram_we),
        .re    (sram_re),
        .addr  (sram_addr),
        .wdata (hwdata),
        .rdata (hrdata)
    );

endmodule

// File: tb/tb_ahb_slave.sv
// tb/tb_ahb_slave.sv - self-checking bench for ahb_slave across several wait-state settings
module tb_ahb_slave;

    localparam int NI = 4;

    logic        hclk = 1'b0;
    logic        hreset;
    logic        hsel_a      [NI];
    logic        hready_a    [NI];
    logic        hwrite_a    [NI];
    logic [31:0] haddr_a     [NI];
    logic [31:0] hwdata_a    [NI];
    logic        hreadyout_a [NI];
    logic [31:0] hrdata_a    [NI];

    logic [31:0] model   [NI][256];
    logic [31:0] last_rd [NI];

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total    = 0;

    always #5 hclk = ~hclk;

    // Instance k has wait states 0, 2, 3, 4
    for (genvar g = 0; g < NI; g++) begin : g_dut
        ahb_slave #(
            .ADDR_BITS   (8),
            .WAIT_STATES ((g == 0) ? 0 : g + 1)
        ) u_dut (
            .hclk      (hclk),
            .hreset    (hreset),
            .hsel      (hsel_a[g]),
            .haddr     (haddr_a[g]),
            .hwrite    (hwrite_a[g]),
            .hready    (hready_a[g]),
            .hwdata    (hwdata_a[g]),
            .hreadyout (hreadyout_a[g]),
            .hrdata    (hrdata_a[g])
        );
    end

    function automatic int ws_of(input int k);
        return (k == 0) ? 0 : k + 1;
    endfunction

    function automatic int idx_of(input logic [31:0] addr);
        return int'((addr / 4) % 256);
    endfunction

    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One full transfer on instance k; optional illegal write pulse to a neighbour index during the first wait cycle
    task automatic xfer(input int k, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wd, input bit violate);
        int          ws;
        int          idx;
        logic [31:0] exp_rd;
        ws  = ws_of(k);
        idx = idx_of(addr);
        chk("idle_ready", 32'(hreadyout_a[k]), 32'd1);
        hsel_a[k]   = 1'b1;
        hready_a[k] = 1'b1;
        haddr_a[k]  = addr;
        hwrite_a[k] = wr;
        step();
        hsel_a[k]   = 1'b0;
        hready_a[k] = 1'b0;
        hwdata_a[k] = wd;
        haddr_a[k]  = $urandom;
        hwrite_a[k] = 1'($urandom);
        for (int i = 0; i < ws; i++) begin
            if (violate && i == 0) begin
                hsel_a[k]   = 1'b1;
                hready_a[k] = 1'b1;
                haddr_a[k]  = addr ^ 32'h4;
                hwrite_a[k] = 1'b1;
            end
            chk("wait_low", 32'(hreadyout_a[k]), 32'd0);
            step();
            hsel_a[k]   = 1'b0;
            hready_a[k] = 1'b0;
        end
        chk("complete_high", 32'(hreadyout_a[k]), 32'd1);
        if (!wr) begin
            exp_rd = model[k][idx];
            chk("rdata", hrdata_a[k], exp_rd);
            last_rd[k] = exp_rd;
        end
        step();
        if (wr) model[k][idx] = wd;
        chk("hold_rdata", hrdata_a[k], last_rd[k]);
    endtask

    initial begin
        hreset = 1'b1;
        for (int k = 0; k < NI; k++) begin
            hsel_a[k] = 1'b0; hready_a[k] = 1'b0; hwrite_a[k] = 1'b0;
            haddr_a[k] = '0;  hwdata_a[k] = '0;   last_rd[k] = '0;
        end
        step();
        step();
        for (int k = 0; k < NI; k++) begin
            chk("reset_ready", 32'(hreadyout_a[k]), 32'd1);
            chk("reset_rdata", hrdata_a[k], 32'd0);
        end
        hreset = 1'b0;
        step();

        // Initialise indices 0..15 through aliased addresses with random upper bits
        for (int k = 0; k < NI; k++) begin
            for (int i = 0; i < 16; i++) begin
                xfer(k, 1'b1, ($urandom & 32'hFFFF_FC00) | 32'(i * 4) | ($urandom & 32'h3),
                     $urandom, 1'b0);
            end
        end

        // Zero wait states: write then read back
        xfer(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
        xfer(0, 1'b0, 32'h0000_0010, 32'h0, 1'b0);
        chk("deadbeef", hrdata_a[0], 32'hDEAD_BEEF);

        // Three wait states
        xfer(2, 1'b1, 32'h0000_0004, 32'h1234_5678, 1'b0);
        xfer(2, 1'b0, 32'h0000_0004, 32'h0, 1'b0);
        chk("w3_readback", hrdata_a[2], 32'h1234_5678);

        // Aliasing
        xfer(0, 1'b1, 32'h0000_0400, 32'hA5A5_A5A5, 1'b0);
        xfer(0, 1'b0, 32'h0000_0000, 32'h0, 1'b0);
        chk("alias_400", hrdata_a[0], 32'hA5A5_A5A5);
        xfer(0, 1'b1, 32'h0000_0013, 32'h1313_1313, 1'b0);
        xfer(0, 1'b0, 32'h0000_0010, 32'h0, 1'b0);
        chk("alias_13", hrdata_a[0], 32'h1313_1313);

        // hready without hsel is not a transfer
        xfer(0, 1'b1, 32'h0000_0008, 32'h0, 1'b0);
        hsel_a[0] = 1'b0; hready_a[0] = 1'b1; haddr_a[0] = 32'h8;
        hwrite_a[0] = 1'b1; hwdata_a[0] = 32'hFFFF_FFFF;
        step();
        chk("nosel_ready0", 32'(hreadyout_a[0]), 32'd1);
        hready_a[0] = 1'b0;
        step();
        chk("nosel_ready1", 32'(hreadyout_a[0]), 32'd1);
        xfer(0, 1'b0, 32'h0000_0008, 32'h0, 1'b0);
        chk("nosel_value", hrdata_a[0], 32'h0);

        // Illegal pulses during WAIT are ignored
        xfer(1, 1'b1, 32'h0000_0030, 32'h55AA_33CC, 1'b1);
        xfer(1, 1'b0, 32'h0000_0030, 32'h0, 1'b1);
        xfer(1, 1'b0, 32'h0000_0034, 32'h0, 1'b0);

        // Reset during the second wait cycle of a write drops it
        xfer(3, 1'b1, 32'h0000_0020, 32'h0BAD_C0DE, 1'b0);
        hsel_a[3] = 1'b1; hready_a[3] = 1'b1; haddr_a[3] = 32'h20; hwrite_a[3] = 1'b1;
        step();
        hsel_a[3] = 1'b0; hready_a[3] = 1'b0; hwdata_a[3] = 32'hCAFE_F00D;
        chk("rst_wait1", 32'(hreadyout_a[3]), 32'd0);
        step();
        chk("rst_wait2", 32'(hreadyout_a[3]), 32'd0);
        hreset = 1'b1;
        step();
        hreset = 1'b0;
        chk("rst_mid_ready", 32'(hreadyout_a[3]), 32'd1);
        chk("rst_mid_rdata", hrdata_a[3], 32'd0);
        for (int k = 0; k < NI; k++) last_rd[k] = '0;
        step();
        chk("rst_idle_ready", 32'(hreadyout_a[3]), 32'd1);
        xfer(3, 1'b0, 32'h0000_0020, 32'h0, 1'b0);
        chk("rst_dropped", hrdata_a[3], 32'h0BAD_C0DE);

        // Random mix against the model
        for (int n = 0; n < 80; n++) begin
            int k;
            int i;
            bit wr;
            bit vio;
            k   = int'($urandom_range(NI - 1, 0));
            i   = int'($urandom_range(15, 0));
            wr  = 1'($urandom);
            vio = (ws_of(k) > 0) && ($urandom_range(3, 0) == 0);
            xfer(k, wr, ($urandom & 32'hFFFF_FC00) | 32'(i * 4) | ($urandom & 32'h3),
                 $urandom, vio);
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
